// File: rtl/shift_mask_pipe.sv
// shift_mask_pipe: pipelined shift / byte-manipulation unit for the integer
// execute cluster. The result is formed combinationally from the offered
// operands and then carried through STAGES register stages. A valid/ready
// handshake with per-stage valid bits gives full throughput and in-order
// retirement. A flush input kills every in-flight op.
`timescale 1ns/1ps
module shift_mask_pipe #(
   parameter int DW     = 64,
   parameter int STAGES = 2,
   parameter int TAGW   = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      in_op,
   input  logic [1:0]      in_size,
   input  logic [DW-1:0]   in_a,
   input  logic [DW-1:0]   in_b,
   input  logic [TAGW-1:0] in_tag,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [DW-1:0]   out_data,
   output logic [TAGW-1:0] out_tag
);

   localparam int NB = DW / 8;
   localparam int BW = $clog2(NB);
   localparam int SW = $clog2(DW);

   // Expand a per-byte enable into a per-bit mask.
   function automatic logic [DW-1:0] byte_mask(input logic [NB-1:0] bm);
      logic [DW-1:0] r;
      for (int i = 0; i < NB; i++) begin
         r[8*i +: 8] = {8{bm[i]}};
      end
      return r;
   endfunction

   logic [2*NB-1:0]      m;       // byte mask of the operand size
   logic [2*NB-1:0]      mb;      // size mask moved to the byte offset
   logic [BW-1:0]        b;       // byte offset
   logic [BW-1:0]        s;       // complementary offset, NB-b modulo NB
   logic [BW+2:0]        sh_b;    // byte offset in bits
   logic [BW+2:0]        sh_s;
   logic [SW-1:0]        amt;     // bit shift amount
   logic signed [DW-1:0] sra_v;
   logic [DW-1:0]        res_d;

   // Operation decode and result formation, ahead of the first register.
   always_comb begin
      case (in_size)
         2'd0:    m = (2*NB)'(8'h01);
         2'd1:    m = (2*NB)'(8'h03);
         2'd2:    m = (2*NB)'(8'h0F);
         default: m = (2*NB)'(8'hFF);
      endcase
      b     = in_b[BW-1:0];
      // Modulo-NB negation; b=0 therefore yields 0 rather than NB.
      s     = BW'(0) - b;
      mb    = m << b;
      sh_b  = {b, 3'b000};
      sh_s  = {s, 3'b000};
      amt   = in_b[SW-1:0];
      sra_v = $signed(in_a) >>> amt;
      res_d = '0;
      case (in_op)
         4'd0: begin
            case (in_size)
               2'd0:    res_d = {{(DW-8){in_b[7]}}, in_b[7:0]};
               2'd1:    res_d = {{(DW-16){in_b[15]}}, in_b[15:0]};
               default: res_d = in_b & byte_mask(m[NB-1:0]);
            endcase
         end
         4'd1:  res_d = in_a >> amt;
         4'd2:  res_d = sra_v;
         4'd3:  res_d = in_a << amt;
         4'd4:  res_d = (in_a >> sh_b) & byte_mask(m[NB-1:0]);
         4'd5:  res_d = (in_a << sh_s) & byte_mask(m[NB-1:0]);
         4'd6:  res_d = (in_a << sh_b) & byte_mask(mb[NB-1:0]);
         4'd7:  res_d = (in_a >> sh_s) & byte_mask(mb[2*NB-1:NB]);
         4'd8:  res_d = in_a & byte_mask(~mb[NB-1:0]);
         4'd9:  res_d = in_a & byte_mask(~mb[2*NB-1:NB]);
         4'd10: res_d = in_a & byte_mask(~in_b[NB-1:0]);
         4'd11: res_d = in_a & byte_mask(in_b[NB-1:0]);
         default: res_d = '0;
      endcase
   end

   logic [STAGES-1:0] vld_vec;
   logic [DW-1:0]     data_vec [STAGES];
   logic [TAGW-1:0]   tag_vec  [STAGES];
   logic [STAGES:0]   adv;     // adv[k]: stage k may load this cycle

   // Advance chain: a stage moves when empty or when the stage after it moves.
   always_comb begin
      adv         = '0;
      adv[STAGES] = out_ready;
      for (int k = STAGES - 1; k >= 0; k--) begin
         adv[k] = ~vld_vec[k] | adv[k+1];
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < STAGES; gi++) begin : stage_g
         logic            vld_q;
         logic [DW-1:0]   data_q;
         logic [TAGW-1:0] tag_q;
         logic            vin;
         logic [DW-1:0]   din;
         logic [TAGW-1:0] tin;

         if (gi == 0) begin : src_in
            assign vin = in_valid;
            assign din = res_d;
            assign tin = in_tag;
         end else begin : src_prev
            assign vin = vld_vec[gi-1];
            assign din = data_vec[gi-1];
            assign tin = tag_vec[gi-1];
         end

         // Stage register: reset clears all, flush kills the valid bit only.
         always_ff @(posedge clk) begin
            if (reset) begin
               vld_q  <= 1'b0;
               data_q <= '0;
               tag_q  <= '0;
            end else if (flush) begin
               vld_q  <= 1'b0;
            end else if (adv[gi]) begin
               vld_q <= vin;
               if (vin) begin
                  data_q <= din;
                  tag_q  <= tin;
               end
            end
         end

         assign vld_vec[gi]  = vld_q;
         assign data_vec[gi] = data_q;
         assign tag_vec[gi]  = tag_q;
      end
   endgenerate

   assign in_ready  = adv[0];
   assign out_valid = vld_vec[STAGES-1];
   assign out_data  = data_vec[STAGES-1];
   assign out_tag   = tag_vec[STAGES-1];

endmodule

// File: tb/tb_shift_mask_pipe.sv
// Scoreboard bench for shift_mask_pipe (DW=64, STAGES=2): accepted ops push
// their expected result from a byte-level reference model; a monitor pops
// and compares whenever the unit retires a result.
`timescale 1ns/1ps
module tb_shift_mask_pipe;

   localparam int DW     = 64;
   localparam int STAGES = 2;
   localparam int TAGW   = 5;

   logic            clk = 1'b0;
   logic            reset, flush, in_valid, in_ready, out_valid, out_ready;
   logic [3:0]      in_op;
   logic [1:0]      in_size;
   logic [DW-1:0]   in_a, in_b, out_data;
   logic [TAGW-1:0] in_tag, out_tag;

   shift_mask_pipe #(.DW(DW), .STAGES(STAGES), .TAGW(TAGW)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_size(in_size), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_tag(out_tag)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0]     data;
      logic [TAGW-1:0] tag;
      int              acc;
      int              stall;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          stall_cnt = 0;
   logic        drv_use_exp = 1'b0;
   logic [63:0] drv_exp = '0;
   logic        rand_bp = 1'b0;
   logic        or_force = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s actual=0x%016h required=0x%016h", name, act, expv);
      end
   endtask

   // Reference: each result byte chosen from the operand bytes by position.
   function automatic logic [63:0] model(input logic [3:0] op, input logic [1:0] sz,
                                         input logic [63:0] a, input logic [63:0] b);
      logic [7:0]  ab [8];
      logic [7:0]  r  [8];
      logic [63:0] res;
      int w, bb, s, sh;
      w  = 1 << sz;
      bb = int'(b[2:0]);
      s  = (8 - bb) % 8;
      sh = int'(b[5:0]);
      res = '0;
      for (int i = 0; i < 8; i++) begin
         ab[i] = a[8*i +: 8];
         r[i]  = 8'h00;
      end
      for (int i = 0; i < 8; i++) begin
         case (op)
            4'd0: if (i < w) r[i] = b[8*i +: 8];
                  else if (sz < 2) r[i] = {8{b[8*w-1]}};
            4'd4: if (i < w && i + bb < 8) r[i] = ab[i+bb];
            4'd5: if (i < w && i >= s) r[i] = ab[i-s];
            4'd6: if (i >= bb && i < bb + w) r[i] = ab[i-bb];
            4'd7: if (i + 8 >= bb && i + 8 < bb + w && i + s < 8) r[i] = ab[i+s];
            4'd8: r[i] = (i >= bb && i < bb + w) ? 8'h00 : ab[i];
            4'd9: r[i] = (i + 8 >= bb && i + 8 < bb + w) ? 8'h00 : ab[i];
            4'd10: r[i] = b[i] ? 8'h00 : ab[i];
            4'd11: r[i] = b[i] ? ab[i] : 8'h00;
            default: ;
         endcase
         res[8*i +: 8] = r[i];
      end
      case (op)
         4'd1: res = a >> sh;
         4'd2: for (int k = 0; k < 64; k++) res[k] = (k + sh < 64) ? a[k+sh] : a[63];
         4'd3: res = a << sh;
         default: ;
      endcase
      return res;
   endfunction

   // Back-pressure: random or forced, changed just after each rising edge.
   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         out_ready = rand_bp ? ($urandom_range(0, 3) != 0) : or_force;
      end
   end

   // Stimulus side of the scoreboard: record every accepted op.
   always @(posedge clk) begin
      exp_t e;
      if (reset || flush) begin
         sb.delete();
      end else if (in_valid && in_ready) begin
         e.data  = drv_use_exp ? drv_exp : model(in_op, in_size, in_a, in_b);
         e.tag   = in_tag;
         e.acc   = cyc;
         e.stall = stall_cnt;
         sb.push_back(e);
      end
      cyc++;
   end

   // Monitor: sampled mid-cycle for the transfer at the next rising edge.
   logic            hold_pend = 1'b0;
   logic [63:0]     hold_data;
   logic [TAGW-1:0] hold_tag;
   always @(negedge clk) begin
      exp_t e;
      #2;
      if (reset) begin
         hold_pend = 1'b0;
      end else begin
         if (!out_ready) stall_cnt++;
         chk("in_ready", 64'(in_ready), 64'(out_ready || (sb.size() < STAGES)));
         if (hold_pend) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_data", out_data, hold_data);
            chk("hold_tag", 64'(out_tag), 64'(hold_tag));
         end
         hold_pend = out_valid && !out_ready && !flush;
         hold_data = out_data;
         hold_tag  = out_tag;
         if (out_valid && out_ready && !flush) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_output actual tag=%0d data=0x%016h required none",
                        out_tag, out_data);
            end else begin
               e = sb.pop_front();
               $display("OUT tag=%0d data=0x%016h expect=0x%016h", out_tag, out_data, e.data);
               chk("out_data", out_data, e.data);
               chk("out_tag", 64'(out_tag), 64'(e.tag));
               if (e.stall == stall_cnt) chk("latency", 64'(cyc - e.acc), 64'(STAGES));
            end
         end
      end
   end

   task automatic idle();
      @(negedge clk);
      in_valid    = 1'b0;
      flush       = 1'b0;
      drv_use_exp = 1'b0;
   endtask

   task automatic send(input logic [3:0] op, input logic [1:0] sz, input logic [63:0] a,
                       input logic [63:0] b, input logic [TAGW-1:0] tag,
                       input logic use_exp, input logic [63:0] expv, input logic fl);
      int guard;
      @(negedge clk);
      in_valid = 1'b1; in_op = op; in_size = sz; in_a = a; in_b = b; in_tag = tag;
      flush = fl; drv_use_exp = use_exp; drv_exp = expv;
      #1;
      guard = 0;
      while (!in_ready && !fl) begin
         @(negedge clk);
         #1;
         guard++;
         if (guard > 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout actual in_ready=0 required 1 tag=%0d", tag);
            break;
         end
      end
      @(posedge clk);
   endtask

   task automatic check_quiet(input string name, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         #1;
         chk(name, 64'(out_valid), 64'd0);
      end
   endtask

   localparam logic [63:0] A0 = 64'h0123456789ABCDEF;
   localparam logic [63:0] ONES = '1;

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
      in_op = '0; in_size = '0; in_a = '0; in_b = '0; in_tag = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", out_data, 64'd0);
      chk("rst_out_tag", 64'(out_tag), 64'd0);

      // Directed vectors with fixed expected results.
      or_force = 1'b1;
      idle();
      idle();
      send(4'd4,  2'd1, A0,   64'd3,    5'd1, 1'b1, 64'h0000000000006789, 1'b0);
      send(4'd2,  2'd3, 64'h8000000000000000, 64'd4, 5'd2, 1'b1, 64'hF800000000000000, 1'b0);
      send(4'd2,  2'd3, 64'h8000000000000000, 64'd0, 5'd3, 1'b1, 64'h8000000000000000, 1'b0);
      send(4'd7,  2'd2, A0,   64'd6,    5'd4, 1'b1, 64'h00000000000089AB, 1'b0);
      send(4'd8,  2'd1, ONES, 64'd7,    5'd5, 1'b1, 64'h00FFFFFFFFFFFFFF, 1'b0);
      send(4'd0,  2'd0, 64'd0, 64'h80,  5'd6, 1'b1, 64'hFFFFFFFFFFFFFF80, 1'b0);
      send(4'd10, 2'd0, ONES, 64'h0F,   5'd7, 1'b1, 64'hFFFFFFFF00000000, 1'b0);
      send(4'd13, 2'd0, ONES, ONES,     5'd8, 1'b1, 64'd0,                1'b0);
      repeat (4) idle();

      // Back-to-back tags 1..6 with the consumer stalled for three cycles.
      or_force = 1'b0;
      idle();
      idle();
      fork
         begin
            for (int t = 1; t <= 6; t++)
               send(4'($urandom_range(0, 11)), 2'($urandom), {$urandom, $urandom},
                    {$urandom, $urandom}, 5'(t), 1'b0, 64'd0, 1'b0);
         end
         begin
            repeat (3) @(posedge clk);
            or_force = 1'b1;
         end
      join
      repeat (6) idle();

      // Flush with two ops in flight and a third offered.
      or_force = 1'b0;
      idle();
      idle();
      send(4'd1, 2'd3, A0, 64'd8,  5'd10, 1'b0, 64'd0, 1'b0);
      send(4'd3, 2'd3, A0, 64'd12, 5'd11, 1'b0, 64'd0, 1'b0);
      send(4'd11, 2'd3, A0, 64'h33, 5'd12, 1'b0, 64'd0, 1'b1);
      idle();
      or_force = 1'b1;
      check_quiet("flush_no_valid", 3);
      send(4'd4, 2'd1, A0, 64'd3, 5'd13, 1'b1, 64'h0000000000006789, 1'b0);
      repeat (4) idle();

      // Same again with reset instead of flush.
      or_force = 1'b0;
      idle();
      idle();
      send(4'd1, 2'd3, A0, 64'd4, 5'd20, 1'b0, 64'd0, 1'b0);
      send(4'd3, 2'd3, A0, 64'd4, 5'd21, 1'b0, 64'd0, 1'b0);
      @(negedge clk);
      in_valid = 1'b1; in_tag = 5'd22; reset = 1'b1;
      @(negedge clk);
      reset = 1'b0; in_valid = 1'b0;
      #1;
      chk("rst2_out_valid", 64'(out_valid), 64'd0);
      chk("rst2_out_data", out_data, 64'd0);
      chk("rst2_in_ready", 64'(in_ready), 64'd1);
      or_force = 1'b1;
      check_quiet("reset_no_valid", 3);
      send(4'd4, 2'd1, A0, 64'd3, 5'd23, 1'b1, 64'h0000000000006789, 1'b0);
      repeat (4) idle();

      // Random traffic with random back-pressure and occasional flush.
      rand_bp = 1'b1;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) idle();
         else send(4'($urandom), 2'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                   5'(i), 1'b0, 64'd0, ($urandom_range(0, 39) == 0));
      end
      idle();
      rand_bp  = 1'b0;
      or_force = 1'b1;
      for (int g = 0; g < 50; g++) begin
         @(negedge clk);
         #3;
         if (sb.size() == 0 && !out_valid) break;
      end
      chk("drain_empty", 64'(sb.size()), 64'd0);
      chk("drain_valid", 64'(out_valid), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
